// File: rtl/lsu_if.sv
// lsu_if: request, data-bus and writeback signals of the load/store unit.
// The master modport is the LSU itself; slave is the core/memory side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
           mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
           wb_we, wb_rd, wb_data, done, err
  );
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
           mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
           wb_we, wb_rd, wb_data, done, err
  );
endinterface

// File: rtl/lsu.sv
// lsu: RV32I load/store unit, one outstanding bus op, load align/extend and regfile writeback.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses with err instead of running them.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic we_q, err_q, err_nx, bad, accept, expired;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic [4:0] rd_q;
  logic [3:0] be, be_q;
  logic [31:0] wd, wd_q, addr_q, ld, wbd_q;
  logic [7:0] lb;
  logic [15:0] lh;
  assign accept = bus.req_valid && state == IDLE;
  assign expired = cnt == LIM;
  assign bus.req_ready = state == IDLE;
  assign bus.mem_valid = state == REQ;
  assign bus.mem_we = state == REQ && we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_be = be_q;
  assign bus.mem_wdata = wd_q;
  assign bus.wb_we = state == WB && rd_q != 5'd0;
  assign bus.wb_rd = rd_q;
  assign bus.wb_data = wbd_q;
  assign bus.done = state == WB || state == DONE;
  assign bus.err = state == DONE && err_q;
  always_comb begin
    bad = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3 == 3'b011)
                     : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
    bad = bad || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
              || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`endif
    be = bus.req_funct3[1:0] == 2'b00 ? 4'b0001 << bus.req_addr[1:0]
       : bus.req_funct3[1:0] == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = bus.req_funct3[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}}
       : bus.req_funct3[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  end
  always_comb begin
    lb = 8'(bus.mem_rdata >> {lo_q, 3'b000});
    lh = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld = f3_q[1:0] == 2'b00 ? {{24{lb[7] && !f3_q[2]}}, lb}
       : f3_q[1:0] == 2'b01 ? {{16{lh[15] && !f3_q[2]}}, lh} : bus.mem_rdata;
  end
  // A handshake on the same cycle the counter expires still completes the op.
  always_comb begin
    state_nx = state;
    err_nx = err_q;
    case (state)
      IDLE: if (accept) begin
        state_nx = bad ? DONE : REQ;
        err_nx = bad;
      end
      REQ: if (bus.mem_ready) state_nx = we_q ? DONE : WAIT;
        else if (expired) begin
          state_nx = DONE;
          err_nx = 1'b1;
        end
      WAIT: if (bus.mem_rvalid) state_nx = WB;
        else if (expired) begin
          state_nx = DONE;
          err_nx = 1'b1;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      lo_q <= 2'd0;
      rd_q <= 5'd0;
      addr_q <= 32'd0;
      be_q <= 4'd0;
      wd_q <= 32'd0;
      wbd_q <= 32'd0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (accept) begin
        cnt <= '0;
        we_q <= bus.req_we;
        f3_q <= bus.req_funct3;
        lo_q <= bus.req_addr[1:0];
        rd_q <= bus.req_rd;
        addr_q <= {bus.req_addr[31:2], 2'b00};
        be_q <= be;
        wd_q <= wd;
      end else if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && bus.mem_rvalid) wbd_q <= ld;
    end
  end
endmodule
